rptr_empty_ctrl: RTL and testbench

Read-side pointer and empty-flag controller for the asynchronous FIFO; the read-domain counterpart of the write pointer/full logic. It advances a binary read address and a Gray-coded read pointer on accepted reads, compares against the write pointer already synchronized into the read clock domain, and produces registered empty, almost-empty, occupancy and underflow indications. It sits between the read-domain consumer, the dual-port memory read address, and the read-to-write pointer synchronizer.

---
 rtl/rptr_empty_ctrl.sv | 87 ++++++++
 tb/tb_rptr_empty_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/rptr_empty_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rptr_empty_ctrl
// Brief    : Read-side pointer, empty/almost-empty, occupancy and underflow
//            control for an asynchronous FIFO (read clock domain).
// Revision : 1.0 - initial release
// ============================================================================
module rptr_empty_ctrl #(
    parameter int unsigned ADDRSIZE      = 9,
    parameter int unsigned AEMPTY_THRESH = 4
) (
    input  logic                rclk,
    input  logic                rrst,
    input  logic                rinc,
    input  logic                rclr_err,
    input  logic [ADDRSIZE:0]   rq2_wptr,
    output logic [ADDRSIZE-1:0] raddr,
    output logic [ADDRSIZE:0]   rptr,
    output logic                rempty,
    output logic                raempty,
    output logic [ADDRSIZE:0]   rcount,
    output logic                runderflow
);

    localparam logic [ADDRSIZE:0] c_AEMPTY_THRESH = AEMPTY_THRESH[ADDRSIZE:0];

    logic [ADDRSIZE:0] r_rbin_q;
    logic [ADDRSIZE:0] r_rptr_q;
    logic              r_rempty_q;
    logic              r_raempty_q;
    logic [ADDRSIZE:0] r_rcount_q;
    logic              r_runderflow_q;

    logic              w_racc;
    logic [ADDRSIZE:0] w_rbin_d;
    logic [ADDRSIZE:0] w_rptr_d;
    logic              w_rempty_d;
    logic              w_raempty_d;
    logic [ADDRSIZE:0] w_rcount_d;
    logic              w_runderflow_d;
    logic [ADDRSIZE:0] w_wbin_s;

    // Gray-to-binary of the synchronized write pointer: bit i is the XOR
    // of all Gray bits from the MSB down to i.
    for (genvar i = 0; i <= ADDRSIZE; i++) begin : g_g2b
        assign w_wbin_s[i] = ^rq2_wptr[ADDRSIZE:i];
    end

    always_comb begin
        w_racc         = rinc & ~r_rempty_q;
        w_rbin_d       = r_rbin_q + {{ADDRSIZE{1'b0}}, w_racc};
        w_rptr_d       = (w_rbin_d >> 1) ^ w_rbin_d;
        w_rempty_d     = (w_rptr_d == rq2_wptr);
        // Modular difference stays correct across the pointer wrap
        w_rcount_d     = w_wbin_s - w_rbin_d;
        w_raempty_d    = (w_rcount_d <= c_AEMPTY_THRESH);
        // Set has priority over clear
        w_runderflow_d = (rinc & r_rempty_q) | (r_runderflow_q & ~rclr_err);
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            r_rbin_q       <= '0;
            r_rptr_q       <= '0;
            r_rempty_q     <= 1'b1;
            r_raempty_q    <= 1'b1;
            r_rcount_q     <= '0;
            r_runderflow_q <= 1'b0;
        end else begin
            r_rbin_q       <= w_rbin_d;
            r_rptr_q       <= w_rptr_d;
            r_rempty_q     <= w_rempty_d;
            r_raempty_q    <= w_raempty_d;
            r_rcount_q     <= w_rcount_d;
            r_runderflow_q <= w_runderflow_d;
        end
    end

    assign raddr      = r_rbin_q[ADDRSIZE-1:0];
    assign rptr       = r_rptr_q;
    assign rempty     = r_rempty_q;
    assign raempty    = r_raempty_q;
    assign rcount     = r_rcount_q;
    assign runderflow = r_runderflow_q;

endmodule
`default_nettype wire

// File: tb/tb_rptr_empty_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rptr_empty_ctrl
// Brief    : Directed bench for rptr_empty_ctrl with an occupancy-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rptr_empty_ctrl;

    localparam int AW  = 3;
    localparam int THR = 1;
    localparam int MOD = 16;

    logic          clk;
    logic          rst;
    logic          rinc;
    logic          rclr;
    logic [AW:0]   rq2_wptr;
    logic [AW-1:0] raddr;
    logic [AW:0]   rptr;
    logic          rempty;
    logic          raempty;
    logic [AW:0]   rcount;
    logic          runderflow;

    int wbin;
    int n_vec;
    int n_err;
    bit chk_en;

    // Model state: read position and occupancy as plain integers
    int m_rbin;
    int m_count;
    bit m_uf;

    function automatic logic [AW:0] bin2gray(input int b);
        logic [AW:0] v;
        v = b[AW:0];
        return v ^ (v >> 1);
    endfunction

    assign rq2_wptr = bin2gray(wbin);

    rptr_empty_ctrl #(.ADDRSIZE(AW), .AEMPTY_THRESH(THR)) dut (
        .rclk       (clk),
        .rrst       (rst),
        .rinc       (rinc),
        .rclr_err   (rclr),
        .rq2_wptr   (rq2_wptr),
        .raddr      (raddr),
        .rptr       (rptr),
        .rempty     (rempty),
        .raempty    (raempty),
        .rcount     (rcount),
        .runderflow (runderflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_rbin  = 0;
            m_count = 0;
            m_uf    = 1'b0;
        end else begin
            if (rinc && m_count == 0)
                m_uf = 1'b1;
            else if (rclr)
                m_uf = 1'b0;
            if (rinc && m_count != 0)
                m_rbin = (m_rbin + 1) % MOD;
            m_count = (wbin - m_rbin + MOD) % MOD;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("raddr",      32'(raddr),      m_rbin % 8);
            check("rptr",       32'(rptr),       int'(bin2gray(m_rbin)));
            check("rcount",     32'(rcount),     m_count);
            check("rempty",     32'(rempty),     (m_count == 0) ? 1 : 0);
            check("raempty",    32'(raempty),    (m_count <= THR) ? 1 : 0);
            check("runderflow", 32'(runderflow), m_uf ? 1 : 0);
        end
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_vec  = 0;
        n_err  = 0;
        chk_en = 1'b0;
        m_rbin = 0; m_count = 0; m_uf = 1'b0;
        rst = 1'b1; rinc = 1'b1; rclr = 1'b0; wbin = 4;   // rq2_wptr = 4'b0110

        // Reset held two cycles with rinc and a nonzero write pointer
        for (int i = 0; i < 2; i++) begin
            cyc();
            chk_en = 1'b1;
            check("rst_rempty",  32'(rempty),     1);
            check("rst_raempty", 32'(raempty),    1);
            check("rst_rcount",  32'(rcount),     0);
            check("rst_rptr",    32'(rptr),       0);
            check("rst_raddr",   32'(raddr),      0);
            check("rst_uf",      32'(runderflow), 0);
        end

        rst = 1'b0; rinc = 1'b0; wbin = 0;
        cyc();
        check("idle_rempty", 32'(rempty), 1);

        // Fill to 3 words, then drain
        wbin = 3;
        cyc();
        check("fill_rempty",  32'(rempty),  0);
        check("fill_rcount",  32'(rcount),  3);
        check("fill_raempty", 32'(raempty), 0);
        rinc = 1'b1;
        cyc();
        check("drain1_raddr",   32'(raddr),   1);
        check("drain1_rcount",  32'(rcount),  2);
        check("drain1_raempty", 32'(raempty), 0);
        cyc();
        check("drain2_raddr",   32'(raddr),   2);
        check("drain2_rcount",  32'(rcount),  1);
        check("drain2_raempty", 32'(raempty), 1);
        cyc();
        check("drain3_raddr",  32'(raddr),  3);
        check("drain3_rcount", 32'(rcount), 0);
        check("drain3_rempty", 32'(rempty), 1);
        check("drain3_rptr",   32'(rptr),   4'b0010);

        // Underflow set, sticky, set-beats-clear, clear
        cyc();
        check("uf_set",   32'(runderflow), 1);
        check("uf_raddr", 32'(raddr),      3);
        rinc = 1'b0;
        cyc();
        check("uf_sticky", 32'(runderflow), 1);
        rinc = 1'b1; rclr = 1'b1;
        cyc();
        check("uf_set_wins", 32'(runderflow), 1);
        rinc = 1'b0;
        cyc();
        check("uf_clear", 32'(runderflow), 0);
        rclr = 1'b0;

        // Full occupancy from a fresh reset
        rst = 1'b1; wbin = 0;
        cyc();
        rst = 1'b0; wbin = 8;
        cyc();
        check("full_rcount", 32'(rcount), 8);
        check("full_rempty", 32'(rempty), 0);
        rinc = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            if (k == 7) check("full_raddr7", 32'(raddr), 7);
        end
        check("full_raddr_wrap", 32'(raddr),  0);
        check("full_rptr",       32'(rptr),   4'b1100);
        check("full_rempty_end", 32'(rempty), 1);

        // Pointer wrap with a steady single word in flight (read + write each cycle)
        rinc = 1'b0; wbin = 9;
        cyc();
        rinc = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            wbin = (wbin + 1) % MOD;
            cyc();
            check("sim_rcount", 32'(rcount), 1);
            check("sim_rempty", 32'(rempty), 0);
            if (k == 7) check("wrap_rptr15", 32'(rptr), 4'b1000);
            if (k == 8) check("wrap_rptr0",  32'(rptr), 4'b0000);
        end
        cyc();
        check("wrap_end_rempty", 32'(rempty), 1);
        check("wrap_end_uf",     32'(runderflow), 0);
        rinc = 1'b0;
        cyc();

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
